// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: CPU/host write requests in, register file write port and status out.
interface reg_write_arbiter_if #(parameter int FIFO_DEPTH = 4);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic          CpuWre;
    logic [4:0]    CpuReg;
    logic [31:0]   CpuData;
    logic          HostValid;
    logic [4:0]    HostReg;
    logic [31:0]   HostData;
    logic          HostReady;
    logic          StallReq;
    logic          RegWre;
    logic [4:0]    WriteReg;
    logic [31:0]   WriteData;
    logic [CW-1:0] HostCount;
    logic          Collision;
    modport master (
        output CpuWre, CpuReg, CpuData, HostValid, HostReg, HostData,
        input  HostReady, StallReq, RegWre, WriteReg, WriteData, HostCount, Collision
    );
    modport slave (
        input  CpuWre, CpuReg, CpuData, HostValid, HostReg, HostData,
        output HostReady, StallReq, RegWre, WriteReg, WriteData, HostCount, Collision
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: merges CPU writeback with buffered host writes onto one register file port.
// Optional REG0_GUARD_EN suppresses the write enable for any write addressed to register 0.
module reg_write_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic CLK,
    input logic Reset,
    reg_write_arbiter_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {NORMAL, STALL} state_t;

    state_t state, nextState;
    logic [7:0] starve, starveNext;
    logic [4:0] regMem [FIFO_DEPTH];
    logic [31:0] dataMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;
    logic stallReq, hostPending, cpuWin, hostWin, push, issue;
    logic [4:0] selReg;
    logic [31:0] selData;
    logic regWre, collision;
    logic [4:0] writeReg;
    logic [31:0] writeData;

    always_comb begin
        hostPending = count != '0;
        cpuWin      = bus.CpuWre && !stallReq;
        hostWin     = !cpuWin && hostPending;
        push        = bus.HostValid && bus.HostReady;
        selReg      = cpuWin ? bus.CpuReg : regMem[rdPtr];
        selData     = cpuWin ? bus.CpuData : dataMem[rdPtr];
`ifdef REG0_GUARD_EN
        issue       = (cpuWin || hostWin) && selReg != 5'd0;
`else
        issue       = cpuWin || hostWin;
`endif
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state  <= NORMAL;
            starve <= 8'd0;
        end else begin
            state  <= nextState;
            starve <= starveNext;
        end
    end

    // The counter only advances while the CPU is actively starving a pending host entry.
    always_comb begin
        starveNext = (state == NORMAL && cpuWin && hostPending) ? starve + 8'd1 : 8'd0;
        nextState  = (state == NORMAL && starveNext == 8'(STARVE_LIMIT)) ? STALL : NORMAL;
    end

    always_comb begin
        stallReq = state == STALL;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            regWre    <= 1'b0;
            writeReg  <= 5'd0;
            writeData <= 32'd0;
            collision <= 1'b0;
        end else begin
            if (push) begin
                regMem[wrPtr]  <= bus.HostReg;
                dataMem[wrPtr] <= bus.HostData;
                wrPtr          <= wrPtr + 1'b1;
            end
            if (hostWin)
                rdPtr <= rdPtr + 1'b1;
            count  <= count + CW'(push) - CW'(hostWin);
            regWre <= issue;
            if (issue) begin
                writeReg  <= selReg;
                writeData <= selData;
            end
            collision <= collision | (bus.CpuWre && stallReq);
        end
    end

    assign bus.HostReady = count < CW'(FIFO_DEPTH);
    assign bus.HostCount = count;
    assign bus.StallReq  = stallReq;
    assign bus.RegWre    = regWre;
    assign bus.WriteReg  = writeReg;
    assign bus.WriteData = writeData;
    assign bus.Collision = collision;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed vectors for reg_write_arbiter with hand-computed expectations.
module tb_reg_write_arbiter;
    logic CLK = 1'b0;
    logic Reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic guardOn;

    reg_write_arbiter_if #(.FIFO_DEPTH(4)) bus();

    reg_write_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .CLK(CLK),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
`ifdef REG0_GUARD_EN
        guardOn = 1'b1;
`else
        guardOn = 1'b0;
`endif
        bus.CpuWre = 0; bus.CpuReg = 0; bus.CpuData = 0;
        bus.HostValid = 0; bus.HostReg = 0; bus.HostData = 0;
        tick();
        tick();
        check("rst_regwre", bus.RegWre, 0);
        check("rst_wreg", bus.WriteReg, 0);
        check("rst_wdata", bus.WriteData, 0);
        check("rst_count", bus.HostCount, 0);
        check("rst_ready", bus.HostReady, 1);
        check("rst_stall", bus.StallReq, 0);
        check("rst_coll", bus.Collision, 0);
        Reset = 0;

        bus.CpuWre = 1; bus.CpuReg = 5; bus.CpuData = 32'hDEADBEEF;
        tick();
        bus.CpuWre = 0;
        check("cpu_regwre", bus.RegWre, 1);
        check("cpu_wreg", bus.WriteReg, 5);
        check("cpu_wdata", bus.WriteData, 32'hDEADBEEF);
        tick();
        check("cpu_idle", bus.RegWre, 0);

        for (int i = 1; i <= 4; i++) begin
            bus.CpuWre = 1; bus.CpuReg = 7; bus.CpuData = 32'h7000_0000 + i;
            bus.HostValid = 1; bus.HostReg = 5'(i); bus.HostData = 32'h11 * i;
            tick();
            check("fill_count", bus.HostCount, i);
            check("fill_cpu", bus.WriteData, 32'h7000_0000 + i);
        end
        check("full_ready", bus.HostReady, 0);
        bus.CpuWre = 0; bus.HostReg = 9; bus.HostData = 32'h99;
        tick();
        bus.HostValid = 0;
        check("drain_reg1", bus.WriteReg, 1);
        check("drain_dat1", bus.WriteData, 32'h11);
        check("drain_cnt1", bus.HostCount, 3);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("drain_wre", bus.RegWre, 1);
            check("drain_reg", bus.WriteReg, i);
            check("drain_dat", bus.WriteData, 32'h11 * i);
            check("drain_cnt", bus.HostCount, 4 - i);
        end
        tick();
        check("drain_done", bus.RegWre, 0);
        check("drain_ready", bus.HostReady, 1);

        bus.CpuWre = 1; bus.CpuReg = 3; bus.CpuData = 32'hC000_0000;
        bus.HostValid = 1; bus.HostReg = 10; bus.HostData = 32'hA5A5A5A5;
        tick();
        bus.HostValid = 0;
        check("starve_push", bus.HostCount, 1);
        for (int i = 1; i <= 8; i++) begin
            bus.CpuData = 32'hC000_0000 + i;
            tick();
            check("starve_stall", bus.StallReq, i == 8);
            check("starve_cpu", bus.WriteData, 32'hC000_0000 + i);
        end
        check("pre_coll", bus.Collision, 0);
        bus.CpuData = 32'hBAD0BAD0;
        tick();
        check("stall_reg", bus.WriteReg, 10);
        check("stall_dat", bus.WriteData, 32'hA5A5A5A5);
        check("stall_end", bus.StallReq, 0);
        check("stall_coll", bus.Collision, 1);
        check("stall_cnt", bus.HostCount, 0);
        bus.CpuData = 32'hC100_0000;
        bus.HostValid = 1; bus.HostReg = 11; bus.HostData = 32'h0B0B0B0B;
        tick();
        bus.HostValid = 0;
        check("post_cpu", bus.WriteData, 32'hC100_0000);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("restart_stall", bus.StallReq, i == 8);
        end
        bus.CpuWre = 0;
        tick();
        check("restart_reg", bus.WriteReg, 11);
        check("restart_dat", bus.WriteData, 32'h0B0B0B0B);
        check("coll_sticky", bus.Collision, 1);

        for (int i = 1; i <= 3; i++) begin
            bus.CpuWre = 1; bus.CpuReg = 7; bus.CpuData = 32'h0;
            bus.HostValid = 1; bus.HostReg = 5'(20 + i); bus.HostData = 32'h5500 + i;
            tick();
        end
        check("pre_rst_cnt", bus.HostCount, 3);
        Reset = 1;
        tick();
        check("mid_rst_cnt", bus.HostCount, 0);
        check("mid_rst_ready", bus.HostReady, 1);
        check("mid_rst_wre", bus.RegWre, 0);
        check("mid_rst_coll", bus.Collision, 0);
        check("mid_rst_stall", bus.StallReq, 0);
        Reset = 0; bus.CpuWre = 0; bus.HostValid = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("no_stale", bus.RegWre, 0);
            check("no_stale_cnt", bus.HostCount, 0);
        end

        bus.CpuWre = 1; bus.CpuReg = 0; bus.CpuData = 32'h12345678;
        tick();
        bus.CpuWre = 0;
        check("r0_cpu_wre", bus.RegWre, !guardOn);
        bus.HostValid = 1; bus.HostReg = 0; bus.HostData = 32'h87654321;
        tick();
        bus.HostValid = 0;
        check("r0_push_cnt", bus.HostCount, 1);
        tick();
        check("r0_host_wre", bus.RegWre, !guardOn);
        check("r0_host_cnt", bus.HostCount, 0);
        if (!guardOn) begin
            check("r0_host_reg", bus.WriteReg, 0);
            check("r0_host_dat", bus.WriteData, 32'h87654321);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
